// File: rtl/mem_ctrl.sv
// Byte-serial single-port memory controller arbitrating between instruction fetch and the
// load/store buffer; little-endian, fair alternation between requesters.
module mem_ctrl (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        _clear,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        _if_req,
    input  logic [31:0] _if_addr,
    output logic        _if_ready,
    output logic [31:0] _if_data,
    input  logic        _lsb_req,
    input  logic        _lsb_wr,
    input  logic [2:0]  _lsb_len,
    input  logic [31:0] _lsb_addr,
    input  logic [31:0] _lsb_wdata,
    output logic        _lsb_ready,
    output logic [31:0] _lsb_rdata
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;  // 1 = LSB owns the port
    logic        last_q, last_d;
    logic        wr_q, wr_d;
    logic [2:0]  len_q, len_d;
    logic [2:0]  idx_q, idx_d;
    logic [2:0]  n;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] buf_q, buf_d, buf_next;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] lsb_rdata_q, lsb_rdata_d;
    logic        if_ok, lsb_ok, grant_lsb, io_stall;

    assign _if_data  = if_data_q;
    assign _lsb_rdata = lsb_rdata_q;

    function automatic logic [31:0] extend(input logic [31:0] v, input logic [2:0] len);
        case (len[1:0])
            2'b00:   return len[2] ? {24'd0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
            2'b01:   return len[2] ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            default: return v;
        endcase
    endfunction

    always_comb begin
        case (len_q[1:0])
            2'b00:   n = 3'd1;
            2'b01:   n = 3'd2;
            default: n = 3'd4;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        wr_d        = wr_q;
        len_d       = len_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        if_data_d   = if_data_q;
        lsb_rdata_d = lsb_rdata_q;
        mem_a       = '0;
        mem_dout    = '0;
        mem_wr      = 1'b0;
        _if_ready   = 1'b0;
        _lsb_ready  = 1'b0;
        // A flush kills pending fetches and loads, but a store is already committed.
        if_ok       = _if_req && !_clear;
        lsb_ok      = _lsb_req && (!_clear || _lsb_wr);
        grant_lsb   = lsb_ok && (!if_ok || !last_q);
        io_stall    = (addr_q[17:16] == 2'b11) && io_buffer_full;

        buf_next = buf_q;
        case (idx_q)
            3'd1:    buf_next[7:0]   = mem_din;
            3'd2:    buf_next[15:8]  = mem_din;
            3'd3:    buf_next[23:16] = mem_din;
            3'd4:    buf_next[31:24] = mem_din;
            default: ;
        endcase

        unique case (state_q)
            StIdle: begin
                if (if_ok || lsb_ok) begin
                    owner_d = grant_lsb;
                    last_d  = grant_lsb;
                    addr_d  = grant_lsb ? _lsb_addr : _if_addr;
                    len_d   = grant_lsb ? _lsb_len : 3'b010;
                    wdata_d = _lsb_wdata;
                    wr_d    = grant_lsb && _lsb_wr;
                    idx_d   = '0;
                    buf_d   = '0;
                    state_d = wr_d ? StWrite : StRead;
                end
            end
            StRead: begin
                if (idx_q < n) mem_a = addr_q + {29'd0, idx_q};
                if (_clear) begin
                    state_d = StIdle;
                end else begin
                    buf_d = buf_next;
                    if (idx_q == n) begin
                        state_d = StDone;
                        if (owner_q) lsb_rdata_d = extend(buf_next, len_q);
                        else         if_data_d   = buf_next;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            StWrite: begin
                mem_a    = addr_q + {29'd0, idx_q};
                mem_dout = wdata_q[{idx_q[1:0], 3'b000} +: 8];
                if (!io_stall) begin
                    mem_wr = 1'b1;
                    if (idx_q == n - 3'd1) state_d = StDone;
                    else                   idx_d   = idx_q + 3'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
                if (wr_q || !_clear) begin
                    if (owner_q) _lsb_ready = 1'b1;
                    else         _if_ready  = 1'b1;
                end
            end
        endcase

        if (!rdy_in) begin
            mem_wr     = 1'b0;
            _if_ready  = 1'b0;
            _lsb_ready = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= StIdle;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            wr_q        <= 1'b0;
            len_q       <= '0;
            idx_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            buf_q       <= '0;
            if_data_q   <= '0;
            lsb_rdata_q <= '0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            wr_q        <= wr_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            if_data_q   <= if_data_d;
            lsb_rdata_q <= lsb_rdata_d;
        end
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Single-port memory controller and arbiter sharing the byte-wide RAM/IO port between instruction fetch (32-bit reads) and the load/store buffer (1/2/4-byte loads and stores). Requests are serialised byte by byte, little-endian. Ownership alternates fairly between the two requesters. Sits between InstFetcher/LoadStoreBuffer and the top-level memory pins, so it directly paces how fast the Issue queue fills and how fast memory ops retire.

## Interface
No parameters.
- clk_in  in  1  system clock; the only clock
- rst_in  in  1  reset, synchronous, active-high
- rdy_in  in  1  global ready; low freezes all state
- _clear  in  1  pipeline flush (branch mispredict)
- mem_din  in  8  RAM read byte; valid one cycle after its address
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  1 = write this cycle
- io_buffer_full  in  1  UART buffer full; stalls IO writes
- _if_req  in  1  fetch request; level, held until _if_ready
- _if_addr  in  32  fetch address; stable while _if_req
- _if_ready  out  1  one-cycle pulse; _if_data valid
- _if_data  out  32  fetched instruction
- _lsb_req  in  1  LSB request; level, held until _lsb_ready
- _lsb_wr  in  1  1 = store, 0 = load
- _lsb_len  in  3  funct3: [1:0] 00 byte / 01 half / 10 word; [2] 1 = zero-extend (loads only)
- _lsb_addr  in  32  byte address; stable while _lsb_req
- _lsb_wdata  in  32  store data; low bytes used
- _lsb_ready  out  1  one-cycle pulse; load data valid or store done
- _lsb_rdata  out  32  sign- or zero-extended load result

## Operation
- States: IDLE, READ, WRITE, DONE. Byte counter `idx` is 3 bits. Byte count N = 4 for fetch, otherwise 1/2/4 from _lsb_len[1:0].
- Reset: state IDLE. All outputs are 0: mem_a, mem_dout, mem_wr, _if_ready, _if_data, _lsb_ready, _lsb_rdata. `last` = LSB, so fetch wins the first tie.
- IDLE arbitration:
  - Only one requester asserting: grant it.
  - Both asserting: grant the one that is not `last`.
  - Latch the requester's addr, len, wdata and wr; `idx` = 0; `last` = grantee.
  - Next state is READ, or WRITE for an LSB store.
  - _clear high in IDLE: fetch and LSB-load requests are ignored that cycle; stores are still granted.
- READ:
  - Drive mem_a = addr + idx while idx < N; mem_wr = 0.
  - The byte on mem_din in the cycle after address k is stored into result byte k.
  - After the last byte is captured, go to DONE.
- WRITE:
  - Drive mem_a = addr + idx, mem_dout = wdata byte idx, mem_wr = 1; increment idx.
  - After byte N-1, go to DONE.
  - IO stall: when addr[17:16] == 2'b11 and io_buffer_full = 1, hold idx and drive mem_wr = 0.
- DONE:
  - Pulse _if_ready or _lsb_ready for one cycle, then go to IDLE.
  - Requests are not sampled in DONE, so a requester updates req/addr on the ready edge.
- Load extension:
  - Byte, signed: bits 31:8 = bit 7. Byte, unsigned: bits 31:8 = 0.
  - Half: same rule using bit 15.
  - Word: unchanged.
- _clear during READ: abort and go to IDLE next cycle; no ready pulse; data is discarded.
- _clear during WRITE or DONE-of-store: the store completes and pulses _lsb_ready (committed stores are never lost).
- _clear during DONE-of-read: the ready pulse is suppressed.
- rdy_in = 0: state, idx and latched data are held; mem_wr forced 0; ready outputs forced 0.
- Address arithmetic wraps modulo 2^32.
- Idle outputs: mem_wr = 0, mem_a = 0, mem_dout = 0.

## Timing
- Grant in cycle T (IDLE).
- Read of N bytes:
  - Addresses driven T+1 … T+N.
  - Bytes arrive T+2 … T+N+1.
  - Ready pulse at T+N+2.
  - 4-byte fetch: ready at T+6. lb: ready at T+3.
- Write of N bytes:
  - Bytes driven T+1 … T+N, plus one cycle per IO-stall cycle.
  - Ready pulse at T+N+1.
- Back-to-back: next grant no earlier than ready+1.
- Worst-case wait for a requester is one full transaction of the other requester.
- _if_data and _lsb_rdata hold their value after the ready pulse until the next completion of the same requester.

## Test plan
- Reset, then _if_req with addr 0x100, RAM bytes 13 05 00 00 → mem_a = 0x100..0x103 on T+1..T+4; _if_ready pulses at T+6 with _if_data = 0x00000513.
- _if_req and _lsb_req both high from reset → fetch granted first, then LSB; with both held continuously, grants alternate IF, LSB, IF.
- lb at 0x200 with byte 0x80 → _lsb_rdata = 0xFFFFFF80 at T+3. lbu same address → 0x00000080. lh with bytes 34 F2 → 0xFFFFF234.
- sw 0xDEADBEEF to 0x300 → mem_wr = 1 with mem_a/mem_dout pairs 300/EF, 301/BE, 302/AD, 303/DE on T+1..T+4; _lsb_ready at T+5.
- sb 0x41 to 0x30000 with io_buffer_full = 1 for 3 cycles → mem_wr stays 0 for 3 cycles, then one write; _lsb_ready is delayed by 3 cycles.
- _clear at T+2 of a fetch → no _if_ready, IDLE at T+3. _clear during a 4-byte store → all 4 bytes written and _lsb_ready still pulses.
